// File: rtl/pid_sequencer.sv
// -----------------------------------------------------------------------------
// pid_sequencer
//   Initiator side of the PID start/wait handshake. Drives the shared start and
//   wait flags into the yaw, roll and pitch rate PIDs. It waits for all three
//   axes to finish, latches their rate outputs as one coherent set, and then
//   releases the PIDs back to rest. A per-phase timer aborts a stuck handshake.
//
// Ports
//   us_clk, resetn            clock, asynchronous active-low reset
//   update_req                one-cycle strobe: new IMU sample, run one pass
//   *_rate_in                 per-axis PID rate_out
//   *_pid_active              per-axis PID pid_active
//   *_pid_complete            per-axis PID pid_complete
//   start_flag, wait_flag     shared handshake controls to all PIDs
//   *_rate_out                latched rate set
//   rates_valid               one-cycle pulse when the latched set updates
//   busy                      high whenever the sequencer is not idle
//   timeout_err               sticky, cleared by the next successful pass
//   overrun_err               sticky until reset, request dropped
//   All outputs are registered.
// -----------------------------------------------------------------------------
module pid_sequencer #(
   parameter int RATE_BIT_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TIMER_WIDTH    = 16
) (
   input  logic                      us_clk,
   input  logic                      resetn,
   input  logic                      update_req,
   input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_in,
   input  logic [RATE_BIT_WIDTH-1:0] roll_rate_in,
   input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_in,
   input  logic                      yaw_pid_active,
   input  logic                      roll_pid_active,
   input  logic                      pitch_pid_active,
   input  logic                      yaw_pid_complete,
   input  logic                      roll_pid_complete,
   input  logic                      pitch_pid_complete,
   output logic                      start_flag,
   output logic                      wait_flag,
   output logic [RATE_BIT_WIDTH-1:0] yaw_rate_out,
   output logic [RATE_BIT_WIDTH-1:0] roll_rate_out,
   output logic [RATE_BIT_WIDTH-1:0] pitch_rate_out,
   output logic                      rates_valid,
   output logic                      busy,
   output logic                      timeout_err,
   output logic                      overrun_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_CALC,
      S_LATCH,
      S_RELEASE
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [TIMER_WIDTH-1:0] r_timer;
   logic [TIMER_WIDTH-1:0] w_timer_nxt;
   logic                   r_pending;
   logic                   w_pending_nxt;

   logic [2:0] w_active;
   logic [2:0] w_complete;
   logic       w_all_idle;
   logic       w_all_running;
   logic       w_all_done;
   logic       w_all_released;
   logic       w_expired;
   logic       w_timeout_hit;

   logic w_start_nxt;
   logic w_wait_nxt;
   logic w_busy_nxt;
   logic w_valid_nxt;
   logic w_latch_en;
   logic w_timeout_nxt;
   logic w_overrun_nxt;

   assign w_active       = {yaw_pid_active, roll_pid_active, pitch_pid_active};
   assign w_complete     = {yaw_pid_complete, roll_pid_complete, pitch_pid_complete};
   // A PID at rest reports complete=1, so "done" also needs active=1.
   assign w_all_idle     = (w_active == 3'b000) && (w_complete == 3'b111);
   assign w_all_running  = (w_active == 3'b111);
   assign w_all_done     = (w_active == 3'b111) && (w_complete == 3'b111);
   assign w_all_released = (w_active == 3'b000);
   assign w_expired      = (r_timer == TIMER_LAST);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Next-state logic. A normal transition is tested before the timeout so it
   // wins when both happen in the same cycle.
   // NOTE: every signal gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      w_state_nxt   = r_state;
      w_timeout_hit = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if ((r_pending || update_req) && w_all_idle) w_state_nxt = S_START;
         end
         S_START: begin
            if (w_all_running) begin
               w_state_nxt = S_CALC;
            end else if (w_expired) begin
               w_state_nxt   = S_RELEASE;
               w_timeout_hit = 1'b1;
            end
         end
         S_CALC: begin
            if (w_all_done) begin
               w_state_nxt = S_LATCH;
            end else if (w_expired) begin
               w_state_nxt   = S_RELEASE;
               w_timeout_hit = 1'b1;
            end
         end
         S_LATCH: begin
            w_state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (w_all_released) begin
               w_state_nxt = S_IDLE;
            end else if (w_expired) begin
               w_state_nxt   = S_IDLE;
               w_timeout_hit = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath next values. The flags are pure functions of the next
   // state, which keeps them registered and glitch-free.
   always_comb begin
      w_start_nxt   = (w_state_nxt == S_START);
      w_wait_nxt    = (w_state_nxt == S_RELEASE);
      w_busy_nxt    = (w_state_nxt != S_IDLE);
      w_valid_nxt   = (r_state == S_LATCH);
      w_latch_en    = (r_state == S_CALC) && w_all_done;
      w_overrun_nxt = overrun_err || (update_req && r_pending);

      w_timeout_nxt = timeout_err;
      if (r_state == S_LATCH)  w_timeout_nxt = 1'b0;
      else if (w_timeout_hit)  w_timeout_nxt = 1'b1;

      // Timer restarts on every state change and only runs in handshake phases.
      w_timer_nxt = '0;
      if ((w_state_nxt == r_state) &&
          ((r_state == S_START) || (r_state == S_CALC) || (r_state == S_RELEASE)))
         w_timer_nxt = r_timer + TIMER_WIDTH'(1);

      // Accepting a request consumes the single pending slot.
      if ((r_state == S_IDLE) && (w_state_nxt == S_START)) w_pending_nxt = 1'b0;
      else                                                 w_pending_nxt = r_pending || update_req;
   end

   // Output registers
   always_ff @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         start_flag     <= 1'b0;
         wait_flag      <= 1'b0;
         busy           <= 1'b0;
         rates_valid    <= 1'b0;
         timeout_err    <= 1'b0;
         overrun_err    <= 1'b0;
         yaw_rate_out   <= '0;
         roll_rate_out  <= '0;
         pitch_rate_out <= '0;
      end else begin
         start_flag  <= w_start_nxt;
         wait_flag   <= w_wait_nxt;
         busy        <= w_busy_nxt;
         rates_valid <= w_valid_nxt;
         timeout_err <= w_timeout_nxt;
         overrun_err <= w_overrun_nxt;
         if (w_latch_en) begin
            yaw_rate_out   <= yaw_rate_in;
            roll_rate_out  <= roll_rate_in;
            pitch_rate_out <= pitch_rate_in;
         end
      end
   end

endmodule

// File: tb/tb_pid_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pid_sequencer
//   Testbench for pid_sequencer. Three behavioural PID models (configurable
//   compute latency, optional hang) answer the handshake. Expected rate sets
//   are queued when a pass is requested and popped when rates_valid pulses.
// -----------------------------------------------------------------------------
module tb_pid_sequencer;

   localparam int W  = 16;
   localparam int TO = 16;

   typedef struct packed {
      logic [W-1:0] yaw;
      logic [W-1:0] roll;
      logic [W-1:0] pitch;
   } rates_t;

   logic         us_clk = 1'b0;
   logic         resetn = 1'b0;
   logic         update_req = 1'b0;
   logic         start_flag, wait_flag, rates_valid, busy, timeout_err, overrun_err;
   logic [W-1:0] yaw_rate_out, roll_rate_out, pitch_rate_out;

   // PID models, index 0 = yaw, 1 = roll, 2 = pitch
   logic [2:0]   m_act;
   logic [2:0]   m_cmp;
   logic [W-1:0] m_rate [3];
   int           m_cnt  [3];
   int           lat    [3];
   bit           hang   [3];
   logic [W-1:0] val    [3];
   logic [2:0]   force_act = 3'b000;
   logic [2:0]   w_act;

   assign w_act = m_act | force_act;

   rates_t exp_q[$];
   rates_t last_good;
   int     errors   = 0;
   int     checks   = 0;
   int     rv_count = 0;

   always #5 us_clk = ~us_clk;

   pid_sequencer #(
      .RATE_BIT_WIDTH(W),
      .TIMEOUT_CYCLES(TO),
      .TIMER_WIDTH(16)
   ) dut (
      .us_clk            (us_clk),
      .resetn            (resetn),
      .update_req        (update_req),
      .yaw_rate_in       (m_rate[0]),
      .roll_rate_in      (m_rate[1]),
      .pitch_rate_in     (m_rate[2]),
      .yaw_pid_active    (w_act[0]),
      .roll_pid_active   (w_act[1]),
      .pitch_pid_active  (w_act[2]),
      .yaw_pid_complete  (m_cmp[0]),
      .roll_pid_complete (m_cmp[1]),
      .pitch_pid_complete(m_cmp[2]),
      .start_flag        (start_flag),
      .wait_flag         (wait_flag),
      .yaw_rate_out      (yaw_rate_out),
      .roll_rate_out     (roll_rate_out),
      .pitch_rate_out    (pitch_rate_out),
      .rates_valid       (rates_valid),
      .busy              (busy),
      .timeout_err       (timeout_err),
      .overrun_err       (overrun_err)
   );

   // Behavioural PID: rest = active 0 / complete 1. start_flag launches a
   // computation; rate_out and complete rise together after lat cycles;
   // wait_flag returns the PID to rest (aborting a hung computation).
   always @(posedge us_clk or negedge resetn) begin
      if (!resetn) begin
         m_act <= 3'b000;
         m_cmp <= 3'b111;
         for (int i = 0; i < 3; i++) begin
            m_rate[i] <= '0;
            m_cnt[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!m_act[i]) begin
               if (start_flag) begin
                  m_act[i] <= 1'b1;
                  m_cmp[i] <= 1'b0;
                  m_cnt[i] <= lat[i];
               end
            end else if (wait_flag) begin
               m_act[i] <= 1'b0;
               m_cmp[i] <= 1'b1;
            end else if (!m_cmp[i] && !hang[i]) begin
               if (m_cnt[i] <= 1) begin
                  m_cmp[i]  <= 1'b1;
                  m_rate[i] <= val[i];
               end else begin
                  m_cnt[i] <= m_cnt[i] - 1;
               end
            end
         end
      end
   end

   always @(negedge us_clk) if (rates_valid === 1'b1) rv_count++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // ---------------------------------------------------------------- helpers
   function automatic logic sig(input int id);
      case (id)
         0:       return start_flag;
         1:       return wait_flag;
         2:       return rates_valid;
         3:       return busy;
         4:       return timeout_err;
         default: return 1'bx;
      endcase
   endfunction

   // Bounded wait on a DUT output, sampled on falling edges.
   task automatic wait_sig(input int id, input logic level, input int budget,
                           output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (n < budget && !ok) begin
         @(negedge us_clk);
         n++;
         if (sig(id) === level) ok = 1'b1;
      end
   endtask

   task automatic set_vals(input rates_t v);
      val[0] = v.yaw;
      val[1] = v.roll;
      val[2] = v.pitch;
   endtask

   // Called at a falling edge; returns at the falling edge after the strobe.
   task automatic pulse_req();
      update_req = 1'b1;
      @(negedge us_clk);
      update_req = 1'b0;
   endtask

   task automatic collect(output bit ok, output rates_t got);
      int n;
      wait_sig(2, 1'b1, 60, ok, n);
      got = {yaw_rate_out, roll_rate_out, pitch_rate_out};
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         lat[i]  = 4;
         hang[i] = 1'b0;
         val[i]  = '0;
      end
      resetn = 1'b0;
      repeat (2) @(negedge us_clk);
      checks++;
      if ({start_flag, wait_flag, rates_valid, busy, timeout_err, overrun_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 000000", {start_flag, wait_flag, rates_valid, busy, timeout_err, overrun_err});
      end
      checks++;
      if ({yaw_rate_out, roll_rate_out, pitch_rate_out} !== 48'h0) begin
         errors++;
         $display("FAIL reset_rates: got %h required 0", {yaw_rate_out, roll_rate_out, pitch_rate_out});
      end
      resetn = 1'b1;
      repeat (3) @(negedge us_clk);
      checks++;
      if (busy !== 1'b0 || start_flag !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b start=%b required 0 0", busy, start_flag);
      end
      last_good = '0;
   endtask

   task automatic test_basic();
      rates_t v, got, exp;
      bit     ok;
      int     n, rv0;
      v = '{yaw: 16'h0100, roll: 16'hFF00, pitch: 16'h7FFF};
      rv0 = rv_count;
      set_vals(v);
      exp_q.push_back(v);
      pulse_req();
      checks++;
      if (start_flag !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_start: start=%b busy=%b required 1 1", start_flag, busy);
      end
      wait_sig(0, 1'b0, 20, ok, n);
      checks++;
      if (!ok || w_act !== 3'b111) begin
         errors++;
         $display("FAIL basic_start_hold: start dropped=%0d active=%b required 1 111", ok, w_act);
      end
      collect(ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL basic_rates: got %h valid=%0d required %h", got, ok, exp);
      end
      checks++;
      if (wait_flag !== 1'b1) begin
         errors++;
         $display("FAIL basic_wait_rise: wait_flag=%b required 1", wait_flag);
      end
      wait_sig(1, 1'b0, 20, ok, n);
      checks++;
      if (!ok || w_act !== 3'b000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_release: wait dropped=%0d active=%b busy=%b required 1 000 0", ok, w_act, busy);
      end
      repeat (3) @(negedge us_clk);
      checks++;
      if (rv_count - rv0 !== 1 || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulses: rates_valid pulses=%0d timeout_err=%b required 1 0", rv_count - rv0, timeout_err);
      end
      last_good = v;
   endtask

   task automatic test_skew();
      rates_t v, got, exp;
      bit     ok, early;
      int     n;
      v = '{yaw: 16'h1234, roll: 16'h5678, pitch: 16'h9ABC};
      lat[0] = 4; lat[1] = 7; lat[2] = 10;
      set_vals(v);
      exp_q.push_back(v);
      pulse_req();
      ok    = 1'b0;
      early = 1'b0;
      for (int k = 0; k < 60 && !ok; k++) begin
         @(negedge us_clk);
         if (rates_valid === 1'b1) ok = 1'b1;
         else if (m_cmp[2] !== 1'b1 && {yaw_rate_out, roll_rate_out, pitch_rate_out} !== last_good) early = 1'b1;
      end
      got = {yaw_rate_out, roll_rate_out, pitch_rate_out};
      checks++;
      if (early) begin
         errors++;
         $display("FAIL skew_early_latch: outputs changed before pitch complete, required held at %h", last_good);
      end
      checks++;
      if (!ok || m_cmp !== 3'b111 || w_act !== 3'b111) begin
         errors++;
         $display("FAIL skew_valid_timing: valid=%0d complete=%b active=%b required 1 111 111", ok, m_cmp, w_act);
      end
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL skew_rates: got %h required %h", got, exp);
      end
      wait_sig(3, 1'b0, 30, ok, n);
      last_good = v;
      lat[1] = 4; lat[2] = 4;
   endtask

   task automatic test_timeout();
      rates_t v, got, exp;
      bit     ok;
      int     n, rv0;
      rv0 = rv_count;
      set_vals('{yaw: 16'hDEAD, roll: 16'hBEEF, pitch: 16'hCAFE});
      hang[1] = 1'b1;
      pulse_req();
      wait_sig(0, 1'b0, 20, ok, n);
      wait_sig(4, 1'b1, 40, ok, n);
      checks++;
      if (!ok || n !== TO) begin
         errors++;
         $display("FAIL timeout_cycles: set=%0d after %0d calc cycles required %0d", ok, n, TO);
      end
      checks++;
      if (wait_flag !== 1'b1 || start_flag !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flags: wait=%b start=%b required 1 0", wait_flag, start_flag);
      end
      checks++;
      if ({yaw_rate_out, roll_rate_out, pitch_rate_out} !== last_good) begin
         errors++;
         $display("FAIL timeout_rates_held: got %h required %h", {yaw_rate_out, roll_rate_out, pitch_rate_out}, last_good);
      end
      wait_sig(3, 1'b0, 40, ok, n);
      repeat (2) @(negedge us_clk);
      checks++;
      if (!ok || rv_count - rv0 !== 0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_no_valid: idle=%0d pulses=%0d timeout_err=%b required 1 0 1", ok, rv_count - rv0, timeout_err);
      end
      hang[1] = 1'b0;
      v = '{yaw: 16'h0011, roll: 16'h0022, pitch: 16'h0033};
      set_vals(v);
      exp_q.push_back(v);
      pulse_req();
      collect(ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp || timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_recover: got %h timeout_err=%b required %h 0", got, timeout_err, exp);
      end
      wait_sig(3, 1'b0, 30, ok, n);
      last_good = v;
   endtask

   task automatic test_back_to_back();
      rates_t v, got, exp;
      bit     ok;
      int     n, rv0;
      v = '{yaw: 16'h0A0A, roll: 16'h0B0B, pitch: 16'h0C0C};
      rv0 = rv_count;
      set_vals(v);
      exp_q.push_back(v);
      exp_q.push_back(v);
      pulse_req();
      repeat (3) @(negedge us_clk);
      pulse_req();
      checks++;
      if (overrun_err !== 1'b0) begin
         errors++;
         $display("FAIL b2b_pending_no_overrun: overrun_err=%b required 0", overrun_err);
      end
      pulse_req();
      checks++;
      if (overrun_err !== 1'b1) begin
         errors++;
         $display("FAIL b2b_overrun: overrun_err=%b required 1", overrun_err);
      end
      for (int p = 0; p < 2; p++) begin
         collect(ok, got);
         exp = exp_q.pop_front();
         checks++;
         if (!ok || got !== exp) begin
            errors++;
            $display("FAIL b2b_rates_pass%0d: got %h valid=%0d required %h", p, got, ok, exp);
         end
      end
      wait_sig(3, 1'b0, 30, ok, n);
      repeat (6) @(negedge us_clk);
      checks++;
      if (rv_count - rv0 !== 2 || busy !== 1'b0 || overrun_err !== 1'b1) begin
         errors++;
         $display("FAIL b2b_two_passes: pulses=%0d busy=%b overrun=%b required 2 0 1", rv_count - rv0, busy, overrun_err);
      end
      last_good = v;
   endtask

   task automatic test_reset_mid();
      rates_t v, got, exp;
      bit     ok;
      int     n;
      set_vals('{yaw: 16'h4444, roll: 16'h5555, pitch: 16'h6666});
      pulse_req();
      wait_sig(0, 1'b0, 20, ok, n);
      @(negedge us_clk);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({start_flag, wait_flag, rates_valid, busy, timeout_err, overrun_err} !== 6'b0 ||
          {yaw_rate_out, roll_rate_out, pitch_rate_out} !== 48'h0) begin
         errors++;
         $display("FAIL reset_mid: ctrl=%b rates=%h required 000000 0",
                  {start_flag, wait_flag, rates_valid, busy, timeout_err, overrun_err},
                  {yaw_rate_out, roll_rate_out, pitch_rate_out});
      end
      @(negedge us_clk);
      resetn = 1'b1;
      @(negedge us_clk);
      v = '{yaw: 16'h7777, roll: 16'h8888, pitch: 16'h9999};
      set_vals(v);
      exp_q.push_back(v);
      pulse_req();
      collect(ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL reset_mid_recover: got %h valid=%0d required %h", got, ok, exp);
      end
      wait_sig(3, 1'b0, 30, ok, n);
      last_good = v;
   endtask

   task automatic test_pending();
      rates_t v, got, exp;
      bit     ok;
      int     n;
      v = '{yaw: 16'h0F0F, roll: 16'hF0F0, pitch: 16'h3C3C};
      set_vals(v);
      force_act = 3'b010;
      exp_q.push_back(v);
      pulse_req();
      repeat (4) @(negedge us_clk);
      checks++;
      if (busy !== 1'b0 || start_flag !== 1'b0) begin
         errors++;
         $display("FAIL pending_hold: busy=%b start=%b required 0 0", busy, start_flag);
      end
      force_act = 3'b000;
      @(negedge us_clk);
      checks++;
      if (start_flag !== 1'b1) begin
         errors++;
         $display("FAIL pending_start: start=%b one cycle after all_idle, required 1", start_flag);
      end
      collect(ok, got);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || got !== exp) begin
         errors++;
         $display("FAIL pending_rates: got %h valid=%0d required %h", got, ok, exp);
      end
      wait_sig(3, 1'b0, 30, ok, n);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL pending_idle: busy did not return to 0");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skew();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_pending();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pid_sequencer.md
Name: pid_sequencer

Overview:
- Initiator side of the PID start/wait handshake. Drives the shared start_flag/wait_flag into the yaw, roll and pitch rate PID instances.
- Waits for all three axes to finish, latches their rate outputs as one coherent set, then releases the PIDs back to their wait state.
- Sits between the IMU sample-ready strobe and the motor mixer.

Parameters:
- RATE_BIT_WIDTH, 16, width of each axis rate input and latched output.
- TIMEOUT_CYCLES, 1000, max us_clk cycles per handshake phase before fault (>=8).
- TIMER_WIDTH, 16, width of the phase timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- us_clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- update_req  input  1  one-cycle strobe: new IMU sample, run one PID pass.
- yaw_rate_in, roll_rate_in, pitch_rate_in  input  RATE_BIT_WIDTH each  PID rate_out per axis.
- yaw_pid_active, roll_pid_active, pitch_pid_active  input  1 each  PID pid_active.
- yaw_pid_complete, roll_pid_complete, pitch_pid_complete  input  1 each  PID pid_complete.
- start_flag  output  1  shared start to all PIDs.
- wait_flag  output  1  shared release to all PIDs.
- yaw_rate_out, roll_rate_out, pitch_rate_out  output  RATE_BIT_WIDTH each  latched rates.
- rates_valid  output  1  one-cycle pulse when the latched rates update.
- busy  output  1  high whenever state != IDLE.
- timeout_err  output  1  sticky; set on phase timeout, cleared by the next successful pass.
- overrun_err  output  1  sticky until reset; update_req arrived while a request was already pending.

Behaviour:
- Reset is asynchronous, active-low. At reset: state=IDLE; every output 0; pending=0; timer=0.
- All outputs are registered. No combinational path from any input to any output.
- Axis status terms:
  - all_idle = all three active==0 and complete==1.
  - all_running = all three active==1.
  - all_done = all three active==1 and complete==1.
- Pending request: update_req sets pending. If update_req arrives while pending is already 1, set overrun_err and keep a single pending request (no queue).
- IDLE:
  - If (pending or update_req) and all_idle: go to START, start_flag<=1, clear pending, timer<=0.
  - If the request is not accepted, pending holds it.
- START:
  - Hold start_flag=1 until all_running. Then start_flag<=0, go to CALC, timer<=0.
  - Note: a PID at rest shows complete=1, so completion is never judged in START.
- CALC:
  - Wait for all_done. Then latch the three rate_in values into the rate_out registers and go to LATCH.
  - Latch only once all_done is seen: PID rate_out updates on the same edge its complete rises.
- LATCH (1 cycle):
  - rates_valid<=1 for this cycle only; timeout_err<=0; wait_flag<=1; go to RELEASE, timer<=0.
- RELEASE:
  - Hold wait_flag=1 until all three active==0. Then wait_flag<=0 and go to IDLE.
- Timeout:
  - In START, CALC and RELEASE the timer counts every cycle.
  - When timer reaches TIMEOUT_CYCLES-1: timeout_err<=1, start_flag<=0, wait_flag<=1, go to RELEASE, timer<=0.
  - Latched rates keep their previous values; no rates_valid pulse.
  - If RELEASE itself times out: wait_flag<=0, go to IDLE.
- Simultaneous events:
  - update_req during any non-IDLE state only sets pending (or overrun_err).
  - A timeout and a normal transition in the same cycle: the normal transition wins.
- Reset mid-operation: all outputs drop to 0 immediately; latched rates are lost.
- Latency from an accepted update_req to rates_valid with an ideal PID: 1 (start) + PID compute + 1 (latch) cycles.

Test Plan:
- Reset, then a behavioural PID model (4-cycle compute) per axis; pulse update_req; models return yaw=16'h0100, roll=16'hFF00, pitch=16'h7FFF → start_flag high until all active, one rates_valid pulse, outputs equal those values, wait_flag drops once all active==0, busy returns 0.
- Axes finish skewed (pitch 6 cycles after yaw) → no latch and no rates_valid until the last axis completes; latched values come from the same pass.
- Roll model never asserts complete, TIMEOUT_CYCLES=16 → timeout_err set after 16 CALC cycles, wait_flag asserted, previous rates unchanged, no rates_valid; next good pass clears timeout_err.
- Two update_req pulses during one pass → first sets pending (second pass starts right after IDLE is reached with all_idle), second sets overrun_err; exactly two rates_valid pulses total.
- resetn asserted while in CALC → start_flag, wait_flag, rates, busy and errors all 0 asynchronously; after release, a new update_req completes normally.
- update_req while one PID still shows active=1 (all_idle false) → stays in IDLE with pending=1; starts within 1 cycle of all_idle.
